// File: rtl/bin_to_bcd_seq_if.sv
// ============================================================================
// Module      : bin_to_bcd_seq_if
// Description : Start/busy/done handshake and result bus of the converter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  done;
    logic                  busy;
    logic                  overflow;

    modport master (
        output start,
        output bin,
        input  bcd,
        input  done,
        input  busy,
        input  overflow
    );

    modport slave (
        input  start,
        input  bin,
        output bcd,
        output done,
        output busy,
        output overflow
    );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter, one bit/clk.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  wire              clk,
    input  wire              rst_n,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   scr_q;
    logic               ovf_scr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               done_q;
    logic               busy_q;

    logic [BCD_W-1:0]   adj_w;
    logic [BCD_W-1:0]   scr_d;
    logic [WIDTH-1:0]   bin_d;
    logic               ovf_scr_d;

    // Each nibble is adjusted independently; carries only move via the shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign adj_w[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? (scr_q[4*i +: 4] + 4'd3)
                                                             : scr_q[4*i +: 4];
    end

    if (BCD_W > 1) begin : g_shift_wide
        assign scr_d = {adj_w[BCD_W-2:0], bin_q[WIDTH-1]};
    end else begin : g_shift_narrow
        assign scr_d = bin_q[WIDTH-1];
    end

    assign bin_d     = bin_q << 1;
    assign ovf_scr_d = ovf_scr_q | adj_w[BCD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        bin_q     <= bus.bin;
                        scr_q     <= '0;
                        ovf_scr_q <= 1'b0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_CONV;
                    end
                end
                S_CONV: begin
                    bin_q     <= bin_d;
                    scr_q     <= scr_d;
                    ovf_scr_q <= ovf_scr_d;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == c_LAST) begin
                        bcd_q   <= scr_d;
                        ovf_q   <= ovf_scr_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Directed bench for bin_to_bcd_seq (3-digit and 2-digit builds).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bin_to_bcd_seq;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] bin;
    logic       sel;
    int         n_tests;
    int         n_fail;

    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(3)) i3 ();
    bin_to_bcd_seq_if #(.WIDTH(8), .DIGITS(2)) i2 ();

    assign i3.start = start & ~sel;
    assign i2.start = start & sel;
    assign i3.bin   = bin;
    assign i2.bin   = bin;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    wire        w_done = sel ? i2.done     : i3.done;
    wire        w_busy = sel ? i2.busy     : i3.busy;
    wire        w_ovf  = sel ? i2.overflow : i3.overflow;
    wire [11:0] w_bcd  = sel ? {4'h0, i2.bcd} : i3.bcd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_conv(input logic [7:0] b, input logic [11:0] exp_bcd,
                           input logic exp_ovf, input string nm);
        int cyc;
        int busy_n;
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = ~b;
        cyc    = 0;
        busy_n = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            n_tests++;
            if (w_busy && w_done) begin
                n_fail++;
                $display("FAIL %s busy_and_done: busy=%0b done=%0b, required not both", nm, w_busy, w_done);
            end
            if (w_busy) busy_n++;
            if (w_done) break;
        end
        n_tests++;
        if (cyc !== 9) begin
            n_fail++;
            $display("FAIL %s latency: done at negedge %0d, required 9", nm, cyc);
        end
        n_tests++;
        if (busy_n !== 8) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, required 8", nm, busy_n);
        end
        n_tests++;
        if (w_bcd !== exp_bcd) begin
            n_fail++;
            $display("FAIL %s bcd: got %h, required %h", nm, w_bcd, exp_bcd);
        end
        n_tests++;
        if (w_ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b, required %b", nm, w_ovf, exp_ovf);
        end
        @(negedge clk);
        n_tests++;
        if (w_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: done=%b one cycle later, required 0", nm, w_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'h00;
        sel   = 1'b0;
        #2;
        n_tests++;
        if (i3.bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h, required 000", i3.bcd); end
        n_tests++;
        if (i3.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", i3.done); end
        n_tests++;
        if (i3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", i3.busy); end
        n_tests++;
        if (i3.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", i3.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(8'd0, 12'h000, 1'b0, "zero");
    endtask

    task automatic test_values();
        do_conv(8'd255, 12'h255, 1'b0, "v255");
        do_conv(8'd99,  12'h099, 1'b0, "v99");
        do_conv(8'd100, 12'h100, 1'b0, "v100");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vals [3];
        logic [11:0] exps [3];
        int cyc;
        vals = '{8'd37, 8'd200, 8'd9};
        exps = '{12'h037, 12'h200, 12'h009};
        @(negedge clk);
        start = 1'b1;
        bin   = vals[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bin = 8'hAA;
            cyc = 0;
            while (cyc < 30) begin
                @(negedge clk);
                cyc++;
                if (w_done) break;
            end
            n_tests++;
            if (cyc !== 9) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: done after %0d cycles, required 9", i, cyc);
            end
            n_tests++;
            if (w_bcd !== exps[i]) begin
                n_fail++;
                $display("FAIL b2b_bcd[%0d]: got %h, required %h", i, w_bcd, exps[i]);
            end
            if (i < 2) bin = vals[i+1];
            else       start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int ndone;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd128;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 2 || c == 5);
            bin   = 8'd77;
            if (w_done) ndone++;
        end
        start = 1'b0;
        n_tests++;
        if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d, required 1", ndone); end
        n_tests++;
        if (w_bcd !== 12'h128) begin n_fail++; $display("FAIL ignore_bcd: got %h, required 128", w_bcd); end
        n_tests++;
        if (w_busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: busy=%b, required 0", w_busy); end
    endtask

    task automatic test_abort();
        int ndone;
        do_conv(8'd55, 12'h055, 1'b0, "pre_abort");
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (i3.bcd !== 12'h000) begin n_fail++; $display("FAIL abort_bcd: got %h, required 000", i3.bcd); end
        n_tests++;
        if (i3.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", i3.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (i3.done) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, required 0", ndone); end
        do_conv(8'd42, 12'h042, 1'b0, "post_abort");
    endtask

    task automatic test_two_digits();
        sel = 1'b1;
        do_conv(8'd100, 12'h000, 1'b1, "d2_100");
        do_conv(8'd255, 12'h055, 1'b1, "d2_255");
        do_conv(8'd99,  12'h099, 1'b0, "d2_99");
        sel = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_values();
        test_back_to_back();
        test_start_ignored();
        test_abort();
        test_two_digits();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
